// File: rtl/rf_ctrl.sv
// rtl/rf_ctrl.sv - register file controller: reset clear sweep, CPU pass-through, debug req/ack access
module rf_ctrl #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_p0_addr,
  input  logic [AW-1:0] cpu_p1_addr,
  input  logic          cpu_re0,
  input  logic          cpu_re1,
  input  logic [AW-1:0] cpu_dst_addr,
  input  logic [DW-1:0] cpu_dst,
  input  logic          cpu_we,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_wr,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] rf_p0_addr,
  output logic [AW-1:0] rf_p1_addr,
  output logic          rf_re0,
  output logic          rf_re1,
  output logic [AW-1:0] rf_dst_addr,
  output logic [DW-1:0] rf_dst,
  output logic          rf_we,
  input  logic [DW-1:0] rf_p0,
  output logic          init_done
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DBG  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  localparam logic [AW:0] LAST_REG = (AW+1)'(NREGS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW:0]   cnt;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  // State register, sweep counter, latched debug request and registered debug outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      cnt       <= '0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_REG) init_done <= 1'b1;
        end
        S_RUN: begin
          if (dbg_req) begin
            wr    <= dbg_wr;
            addr  <= dbg_addr;
            wdata <= dbg_wdata;
          end
        end
        S_DBG: begin
          dbg_ack <= 1'b1;
          // the register file produced this data on the mid-cycle negedge
          if (!wr) dbg_rdata <= rf_p0;
        end
        S_ACK: begin
          dbg_ack <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Next state and register-file port steering; CPU passes through unless INIT or DBG owns the ports
  always_comb begin
    state_nxt   = state;
    rf_p0_addr  = cpu_p0_addr;
    rf_p1_addr  = cpu_p1_addr;
    rf_re0      = cpu_re0;
    rf_re1      = cpu_re1;
    rf_dst_addr = cpu_dst_addr;
    rf_dst      = cpu_dst;
    // reg0 is hardwired to zero, so writes to it never reach the array
    rf_we       = cpu_we && (cpu_dst_addr != '0);
    cpu_stall   = 1'b0;
    case (state)
      S_INIT: begin
        rf_p0_addr  = '0;
        rf_p1_addr  = '0;
        rf_re0      = 1'b0;
        rf_re1      = 1'b0;
        rf_dst_addr = cnt[AW-1:0];
        rf_dst      = '0;
        rf_we       = 1'b1;
        cpu_stall   = 1'b1;
        if (cnt == LAST_REG) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (dbg_req) state_nxt = S_DBG;
      end
      S_DBG: begin
        rf_p0_addr  = addr;
        rf_p1_addr  = '0;
        rf_re0      = !wr;
        rf_re1      = 1'b0;
        rf_dst_addr = addr;
        rf_dst      = wdata;
        rf_we       = wr && (addr != '0);
        cpu_stall   = 1'b1;
        state_nxt   = S_ACK;
      end
      S_ACK: begin
        state_nxt = S_RUN;
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_rf_ctrl.sv
// tb/tb_rf_ctrl.sv - self-checking bench for rf_ctrl with a negedge register-file model
module tb_rf_ctrl;
  logic        clk;
  logic        rst_n;
  logic [3:0]  cpu_p0_addr, cpu_p1_addr, cpu_dst_addr;
  logic        cpu_re0, cpu_re1, cpu_we;
  logic [15:0] cpu_dst;
  logic        cpu_stall;
  logic        dbg_req, dbg_wr, dbg_ack;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic [3:0]  rf_p0_addr, rf_p1_addr, rf_dst_addr;
  logic        rf_re0, rf_re1, rf_we;
  logic [15:0] rf_dst, rf_p0;
  logic        init_done;

  logic [15:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  rf_ctrl #(.NREGS(16), .AW(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_p0_addr(cpu_p0_addr), .cpu_p1_addr(cpu_p1_addr),
    .cpu_re0(cpu_re0), .cpu_re1(cpu_re1),
    .cpu_dst_addr(cpu_dst_addr), .cpu_dst(cpu_dst), .cpu_we(cpu_we),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_p0_addr(rf_p0_addr), .rf_p1_addr(rf_p1_addr),
    .rf_re0(rf_re0), .rf_re1(rf_re1),
    .rf_dst_addr(rf_dst_addr), .rf_dst(rf_dst), .rf_we(rf_we),
    .rf_p0(rf_p0), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: samples the controller's ports on the negedge
  always @(negedge clk) begin
    if (rf_we) mem[rf_dst_addr] <= rf_dst;
    if (rf_re0) rf_p0 <= mem[rf_p0_addr];
  end

  typedef struct {
    logic [3:0]  p0, p1;
    logic        re0, re1;
    logic [3:0]  da;
    logic [15:0] d;
    logic        we;
    logic        exp_we;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // releases reset and walks the clear sweep; optionally raises a debug read of R5 at cycle req_at
  task automatic do_sweep(input int req_at);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == req_at) begin
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 4'd5; dbg_wdata = 16'h0;
      end
      #1;
      chk("sweep_ctl", {26'd0, rf_we, rf_re0, rf_re1, cpu_stall, init_done, dbg_ack}, 32'b100100);
      chk("sweep_addr", {28'd0, rf_dst_addr}, i);
      chk("sweep_data", {16'd0, rf_dst}, 32'd0);
      step();
    end
    #1;
    chk("sweep_done", {30'd0, init_done, cpu_stall}, 32'b10);
  endtask

  // issues one debug access starting in the current RUN cycle and waits (bounded) for the ack
  task automatic dbg_op(input logic w, input logic [3:0] a, input logic [15:0] d,
                        output int ack_at, output int stalls, output logic we_dbg,
                        output logic cyc0_we);
    dbg_req = 1'b1; dbg_wr = w; dbg_addr = a; dbg_wdata = d;
    #1;
    cyc0_we = rf_we;
    stalls  = cpu_stall ? 1 : 0;
    ack_at  = 99;
    we_dbg  = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      cpu_we = 1'b0;
      #1;
      if (cpu_stall) begin
        stalls++;
        we_dbg = we_dbg | rf_we;
      end
      if (dbg_ack) begin
        ack_at  = k;
        dbg_req = 1'b0;
        break;
      end
    end
  endtask

  int   ack_at, stalls;
  logic we_dbg, cyc0_we;

  initial begin
    vecs[0] = '{p0:4'd1, p1:4'd2, re0:1, re1:1, da:4'd7,  d:16'h1111, we:1, exp_we:1};
    vecs[1] = '{p0:4'd15, p1:4'd0, re0:1, re1:0, da:4'd0, d:16'h1234, we:1, exp_we:0};
    vecs[2] = '{p0:4'd3, p1:4'd4, re0:0, re1:1, da:4'd15, d:16'hFFFF, we:0, exp_we:0};
    vecs[3] = '{p0:4'd8, p1:4'd9, re0:1, re1:1, da:4'd1,  d:16'h0001, we:1, exp_we:1};

    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    rf_p0 = 16'h0;
    rst_n = 1'b1;
    cpu_p0_addr = 0; cpu_p1_addr = 0; cpu_re0 = 0; cpu_re1 = 0;
    cpu_dst_addr = 0; cpu_dst = 0; cpu_we = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_ctl", {26'd0, rf_we, rf_re0, rf_re1, cpu_stall, init_done, dbg_ack}, 32'b100100);
    chk("reset_addr", {12'd0, rf_dst_addr, rf_dst}, 32'd0);
    chk("reset_rdata", {16'd0, dbg_rdata}, 32'd0);
    step();
    do_sweep(-1);
    chk("cleared_r0_r5_r15", {mem[0], mem[5] | mem[15]}, 32'd0);

    // CPU pass-through vectors in RUN
    for (int v = 0; v < 4; v++) begin
      cpu_p0_addr = vecs[v].p0; cpu_p1_addr = vecs[v].p1;
      cpu_re0 = vecs[v].re0; cpu_re1 = vecs[v].re1;
      cpu_dst_addr = vecs[v].da; cpu_dst = vecs[v].d; cpu_we = vecs[v].we;
      #1;
      chk("pass_rd", {22'd0, rf_p0_addr, rf_p1_addr, rf_re0, rf_re1},
          {22'd0, vecs[v].p0, vecs[v].p1, vecs[v].re0, vecs[v].re1});
      chk("pass_wr", {11'd0, rf_we, rf_dst_addr, rf_dst}, {11'd0, vecs[v].exp_we, vecs[v].da, vecs[v].d});
      chk("pass_stall", {31'd0, cpu_stall}, 32'd0);
      step();
    end
    cpu_we = 0; cpu_re0 = 0; cpu_re1 = 0;
    chk("pass_mem", {mem[7], mem[1]}, {16'h1111, 16'h0001});
    chk("pass_r0", {16'd0, mem[0]}, 32'd0);

    // debug write R5 then read back
    dbg_op(1'b1, 4'd5, 16'hBEEF, ack_at, stalls, we_dbg, cyc0_we);
    chk("dwr_ack_lat", ack_at, 2);
    chk("dwr_stalls", stalls, 1);
    chk("dwr_we", {31'd0, we_dbg}, 1);
    chk("dwr_mem", {16'd0, mem[5]}, 32'hBEEF);
    step();
    chk("dwr_ack_pulse", {31'd0, dbg_ack}, 0);
    dbg_op(1'b0, 4'd5, 16'h0, ack_at, stalls, we_dbg, cyc0_we);
    chk("drd_ack_lat", ack_at, 2);
    chk("drd_stalls", stalls, 1);
    chk("drd_rdata", {16'd0, dbg_rdata}, 32'hBEEF);
    step();

    // reg0 protection from both requesters
    cpu_dst_addr = 4'd0; cpu_dst = 16'h1234; cpu_we = 1'b1;
    #1;
    chk("cpu_r0_we", {31'd0, rf_we}, 0);
    step();
    cpu_we = 1'b0;
    dbg_op(1'b1, 4'd0, 16'hFFFF, ack_at, stalls, we_dbg, cyc0_we);
    chk("dwr0_ack_lat", ack_at, 2);
    chk("dwr0_we", {31'd0, we_dbg}, 0);
    chk("dwr0_rdata_held", {16'd0, dbg_rdata}, 32'hBEEF);
    step();
    dbg_op(1'b0, 4'd0, 16'h0, ack_at, stalls, we_dbg, cyc0_we);
    chk("drd0_ack_lat", ack_at, 2);
    chk("drd0_rdata", {16'd0, dbg_rdata}, 32'h0);
    step();

    // CPU write and debug read of the same register in one RUN cycle
    cpu_dst_addr = 4'd3; cpu_dst = 16'h00AA; cpu_we = 1'b1;
    dbg_op(1'b0, 4'd3, 16'h0, ack_at, stalls, we_dbg, cyc0_we);
    chk("coll_cpu_we", {31'd0, cyc0_we}, 1);
    chk("coll_ack_lat", ack_at, 2);
    chk("coll_rdata", {16'd0, dbg_rdata}, 32'h00AA);
    step();

    // reset in the DBG cycle drops the access
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'h5555;
    step();
    dbg_req = 1'b0;
    chk("mid_dbg_stall", {31'd0, cpu_stall}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {26'd0, rf_we, rf_re0, rf_re1, cpu_stall, init_done, dbg_ack}, 32'b100100);
    chk("mid_rst_regs", {12'd0, rf_dst_addr, dbg_rdata}, 32'd0);
    step();
    chk("mid_rst_noack", {31'd0, dbg_ack}, 0);
    step();
    chk("mid_rst_noack2", {31'd0, dbg_ack}, 0);

    // fresh sweep with a debug read raised during INIT
    do_sweep(3);
    chk("init_req_clear", {16'd0, mem[9] | mem[5] | mem[3]}, 32'd0);
    step();
    #1;
    chk("init_req_dbg", {30'd0, cpu_stall, dbg_ack}, 32'b10);
    step();
    #1;
    chk("init_req_ack", {31'd0, dbg_ack}, 1);
    chk("init_req_rdata", {16'd0, dbg_rdata}, 32'h0);
    dbg_req = 1'b0;
    step();
    chk("init_req_ack_pulse", {31'd0, dbg_ack}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_ctrl.md
# rf_ctrl

Controller for the block-SRAM register file. After reset it clears all registers, then shares the register file's two read ports and single write port between the CPU pipeline and a debug/loader requester. The debug requester uses a req/ack handshake; the CPU is stalled for the one cycle the debug access owns the register file. The block sits between the CPU decode/writeback stages and the register file, on the CPU clock.

## Interface
- NREGS, 16, number of registers; the init sweep covers 0..NREGS-1
- AW, 4, register address width
- DW, 16, data width
- clk  in  1  system clock; the register file samples on the negedge of the same clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_p0_addr, cpu_p1_addr  in  AW  CPU read addresses
- cpu_re0, cpu_re1  in  1  CPU read enables
- cpu_dst_addr  in  AW  CPU write address
- cpu_dst  in  DW  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_stall  out  1  CPU must hold its state; CPU requests are ignored while high
- dbg_req  in  1  debug request; held high until dbg_ack
- dbg_wr  in  1  1 = write, 0 = read; sampled with dbg_req
- dbg_addr  in  AW  debug register address
- dbg_wdata  in  DW  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  read result; valid while dbg_ack is high and held until the next debug read
- rf_p0_addr, rf_p1_addr  out  AW  register file read addresses
- rf_re0, rf_re1  out  1  register file read enables
- rf_dst_addr  out  AW  register file write address
- rf_dst  out  DW  register file write data
- rf_we  out  1  register file write enable
- rf_p0  in  DW  register file port-0 read data
- init_done  out  1  high once the clear sweep has completed

## Operation
**States**
- INIT, RUN, DBG, ACK.
- Registered signals: `state`, sweep counter `cnt` (AW+1 bits), a latched debug request (`wr`, `addr`, `wdata`), `dbg_ack`, `dbg_rdata`, `init_done`.
- The rf_* outputs and cpu_stall are combinational from the state registers and the CPU inputs.

**INIT**
- Drive rf_we=1, rf_dst_addr=cnt[AW-1:0], rf_dst=0, rf_re0=rf_re1=0, cpu_stall=1.
- Increment cnt every cycle.
- When cnt==NREGS-1, go to RUN and set init_done=1.

**RUN**
- Pass CPU signals straight through to the register file, with cpu_stall=0.
- Exception: a CPU write to address 0 is suppressed (rf_we=0), because reg0 is hardwired to zero.
- If dbg_req=1, latch dbg_wr, dbg_addr and dbg_wdata, then go to DBG. The CPU access in that same cycle still completes.

**DBG** (exactly one cycle)
- cpu_stall=1.
- CPU requests are blocked: rf_we and rf_re1 are 0, and rf_re0 is used only by a debug read.
- Debug write: rf_we = (addr != 0), rf_dst_addr=addr, rf_dst=wdata.
- Debug read: rf_re0=1, rf_p0_addr=addr. At the closing posedge, capture rf_p0 into dbg_rdata; the register file updated it on the mid-cycle negedge.
- Next state is ACK, with dbg_ack=1.

**ACK** (one cycle)
- dbg_ack=1; CPU passes through as in RUN.
- dbg_req is ignored in this cycle.
- Next state is RUN, with dbg_ack=0.

**Rules**
- The requester must drop dbg_req in the cycle after ACK. A request still high in RUN is treated as a new access.
- Debug writes to address 0 are acked but not performed.
- Reset reads of reg0 return 0 because the sweep cleared it.

## Timing
**Reset values** (state=INIT, cnt=0)
- cpu_stall=1, init_done=0, dbg_ack=0, dbg_rdata=0.
- rf_we=1, rf_dst_addr=0, rf_dst=0, rf_re0=rf_re1=0.

**Latencies**
- init_done rises NREGS posedges after rst_n deasserts, and stays high until reset.
- Debug latency: dbg_ack is high 2 cycles after the first cycle dbg_req is sampled high in RUN.
- CPU is stalled for exactly 1 cycle per debug access.
- Reads are transparent to the CPU: CPU read data appears on the register file's p0/p1 after the negedge of the cycle in which the read enables are high.

**Simultaneous events**
- dbg_req rising during INIT is held off. It is serviced starting from the first RUN cycle.
- A CPU write and a debug request in the same RUN cycle: the CPU write occurs first, the debug access the next cycle. A debug read of the same address therefore returns the new CPU value.

**Reset mid-operation**
- Asserting rst_n at any point (including DBG or ACK) returns the block to INIT immediately with cnt=0.
- Any pending debug access is dropped with no ack.
- The full sweep reruns.

## Test plan
- **Reset and sweep:** release rst_n with NREGS=16 → rf_we=1 for 16 cycles with addresses 0..15 and data 0; cpu_stall=1 throughout; init_done=1 and cpu_stall=0 on cycle 17.
- **Debug write/read:** debug write 0xBEEF to R5, then debug read R5 → dbg_ack 2 cycles after each req; dbg_rdata=0xBEEF; cpu_stall high for exactly one cycle per access.
- **Reg0 protection:** CPU we to R0 with 0x1234, and debug write R0=0xFFFF → rf_we stays 0 in both; a debug read of R0 returns 0x0000; the debug write is still acked.
- **Collision:** in the same RUN cycle, CPU writes R3=0x00AA and dbg_req reads R3 → CPU write goes through, debug read occurs next cycle, dbg_rdata=0x00AA.
- **Request during INIT:** dbg_req raised 3 cycles after reset release → no ack until after init_done; ack arrives 2 cycles after the first RUN cycle.
- **Reset mid-DBG:** assert rst_n in the DBG cycle → dbg_ack never pulses; outputs return to reset values; a fresh 16-cycle sweep follows.
